// File: rtl/cvxif_offload_issuer.sv
// cvxif_offload_issuer: core-side CV-X-IF initiator.
// Takes one offload candidate from decode, drives the issue handshake,
// commits or kills it, then waits for the coprocessor result and returns
// it to the core register file. Only one instruction is in flight at a time.
// Optional build macro: CVXIF_TIMEOUT_EN bounds the result wait to
// TIMEOUT_CYCLES cycles and reports expiry on timeout_o.
module cvxif_offload_issuer #(
    parameter int XLEN           = 64,
    parameter int ID_WIDTH       = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                instr_valid_i,
    output logic                instr_ready_o,
    input  logic [31:0]         instr_i,
    input  logic [XLEN-1:0]     rs1_i,
    input  logic [XLEN-1:0]     rs2_i,
    input  logic [ID_WIDTH-1:0] id_i,
    input  logic                flush_i,
    output logic                x_issue_valid_o,
    input  logic                x_issue_ready_i,
    output logic [31:0]         x_issue_instr_o,
    output logic [XLEN-1:0]     x_issue_rs1_o,
    output logic [XLEN-1:0]     x_issue_rs2_o,
    output logic [ID_WIDTH-1:0] x_issue_id_o,
    input  logic                x_issue_accept_i,
    input  logic                x_issue_writeback_i,
    input  logic                x_issue_exc_i,
    output logic                x_commit_valid_o,
    output logic [ID_WIDTH-1:0] x_commit_id_o,
    output logic                x_commit_kill_o,
    input  logic                x_result_valid_i,
    output logic                x_result_ready_o,
    input  logic [ID_WIDTH-1:0] x_result_id_i,
    input  logic [XLEN-1:0]     x_result_data_i,
    input  logic [4:0]          x_result_rd_i,
    input  logic                x_result_we_i,
    output logic                wb_valid_o,
    output logic [XLEN-1:0]     wb_data_o,
    output logic [4:0]          wb_rd_o,
    output logic                illegal_o,
    output logic                done_o,
    output logic                result_err_o,
    output logic                timeout_o
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        COMMIT,
        WAIT_RESULT
    } state_t;

    state_t state_q, state_d;

    logic [31:0]         instr_q;
    logic [XLEN-1:0]     rs1_q;
    logic [XLEN-1:0]     rs2_q;
    logic [ID_WIDTH-1:0] id_q;

    logic kill_q, kill_d;
    logic wb_en_q, wb_en_d;
    logic exc_q, exc_d;
    logic latch_en;
    logic result_match;

    logic illegal_d, done_d, result_err_d, wb_valid_d;

`ifdef CVXIF_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_q;
    logic          timeout_d;
`endif

    assign x_issue_instr_o = instr_q;
    assign x_issue_rs1_o   = rs1_q;
    assign x_issue_rs2_o   = rs2_q;
    assign x_issue_id_o    = id_q;
    assign x_commit_id_o   = id_q;

    // Next-state, handshake outputs and next values of the registered pulses
    always_comb begin
        state_d          = state_q;
        kill_d           = kill_q;
        wb_en_d          = wb_en_q;
        exc_d            = exc_q;
        latch_en         = 1'b0;
        instr_ready_o    = 1'b0;
        x_issue_valid_o  = 1'b0;
        x_commit_valid_o = 1'b0;
        x_commit_kill_o  = 1'b0;
        x_result_ready_o = 1'b0;
        illegal_d        = 1'b0;
        done_d           = 1'b0;
        result_err_d     = 1'b0;
        wb_valid_d       = 1'b0;
        result_match     = x_result_valid_i && (x_result_id_i == id_q);
`ifdef CVXIF_TIMEOUT_EN
        timeout_d        = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                instr_ready_o = 1'b1;
                kill_d        = 1'b0;
                if (instr_valid_i && !flush_i) begin
                    latch_en = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                x_issue_valid_o = 1'b1;
                if (flush_i) begin
                    kill_d = 1'b1;
                end
                if (x_issue_ready_i) begin
                    if (!x_issue_accept_i) begin
                        illegal_d = !(kill_q || flush_i);
                        state_d   = IDLE;
                    end else begin
                        wb_en_d = x_issue_writeback_i;
                        exc_d   = x_issue_exc_i;
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                x_commit_valid_o = 1'b1;
                x_commit_kill_o  = kill_q || flush_i;
                if (kill_q || flush_i) begin
                    state_d = IDLE;
                end else if (!wb_en_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_RESULT;
                end
            end
            WAIT_RESULT: begin
                x_result_ready_o = 1'b1;
                if (flush_i) begin
                    kill_d = 1'b1;
                end
                if (result_match) begin
                    wb_valid_d = x_result_we_i && !kill_q && !flush_i;
                    state_d    = IDLE;
                end else if (x_result_valid_i) begin
                    result_err_d = 1'b1;
                end
`ifdef CVXIF_TIMEOUT_EN
                if (!result_match && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1))) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register plus the flags that follow one instruction through the FSM
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            kill_q  <= 1'b0;
            wb_en_q <= 1'b0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
            wb_en_q <= wb_en_d;
            exc_q   <= exc_d;
        end
    end

    // Issue payload is captured once in IDLE and held until the next candidate
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instr_q <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            id_q    <= '0;
        end else if (latch_en) begin
            instr_q <= instr_i;
            rs1_q   <= rs1_i;
            rs2_q   <= rs2_i;
            id_q    <= id_i;
        end
    end

    // One-cycle status pulses and the register-file writeback port
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            illegal_o    <= 1'b0;
            done_o       <= 1'b0;
            result_err_o <= 1'b0;
            wb_valid_o   <= 1'b0;
            wb_data_o    <= '0;
            wb_rd_o      <= '0;
        end else begin
            illegal_o    <= illegal_d;
            done_o       <= done_d;
            result_err_o <= result_err_d;
            wb_valid_o   <= wb_valid_d;
            if (wb_valid_d) begin
                wb_data_o <= x_result_data_i;
                wb_rd_o   <= x_result_rd_i;
            end
        end
    end

`ifdef CVXIF_TIMEOUT_EN
    // Wait counter sits at zero outside WAIT_RESULT so it starts fresh on entry
    always_ff @(posedge clk_i) begin
        if (rst_i || (state_q != WAIT_RESULT)) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    // Timeout pulse is registered like the other status pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= timeout_d;
        end
    end
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_cvxif_offload_issuer.sv
// Directed self-checking bench for cvxif_offload_issuer.
// Inputs change just after each falling edge, outputs are sampled 1ns later,
// so every check sees the values of the current clock cycle.
module tb_cvxif_offload_issuer;

    localparam int XLEN = 64;
    localparam int IDW  = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            instr_valid, instr_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] rs1, rs2;
    logic [IDW-1:0]  id;
    logic            flush;
    logic            iss_valid, iss_ready;
    logic [31:0]     iss_instr;
    logic [XLEN-1:0] iss_rs1, iss_rs2;
    logic [IDW-1:0]  iss_id;
    logic            iss_accept, iss_wb, iss_exc;
    logic            cmt_valid, cmt_kill;
    logic [IDW-1:0]  cmt_id;
    logic            res_valid, res_ready;
    logic [IDW-1:0]  res_id;
    logic [XLEN-1:0] res_data;
    logic [4:0]      res_rd;
    logic            res_we;
    logic            wb_valid;
    logic [XLEN-1:0] wb_data;
    logic [4:0]      wb_rd;
    logic            illegal, done, res_err, timeout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cvxif_offload_issuer #(.XLEN(XLEN), .ID_WIDTH(IDW), .TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
        .instr_i(instr), .rs1_i(rs1), .rs2_i(rs2), .id_i(id), .flush_i(flush),
        .x_issue_valid_o(iss_valid), .x_issue_ready_i(iss_ready),
        .x_issue_instr_o(iss_instr), .x_issue_rs1_o(iss_rs1), .x_issue_rs2_o(iss_rs2),
        .x_issue_id_o(iss_id), .x_issue_accept_i(iss_accept),
        .x_issue_writeback_i(iss_wb), .x_issue_exc_i(iss_exc),
        .x_commit_valid_o(cmt_valid), .x_commit_id_o(cmt_id), .x_commit_kill_o(cmt_kill),
        .x_result_valid_i(res_valid), .x_result_ready_o(res_ready),
        .x_result_id_i(res_id), .x_result_data_i(res_data), .x_result_rd_i(res_rd),
        .x_result_we_i(res_we),
        .wb_valid_o(wb_valid), .wb_data_o(wb_data), .wb_rd_o(wb_rd),
        .illegal_o(illegal), .done_o(done), .result_err_o(res_err), .timeout_o(timeout)
    );

    // Advance to the next cycle and return all control inputs to their quiet values
    task automatic tick();
        @(negedge clk);
        instr_valid = 1'b0; flush = 1'b0;
        iss_ready = 1'b0; iss_accept = 1'b0; iss_wb = 1'b0; iss_exc = 1'b0;
        res_valid = 1'b0; res_id = '0; res_data = '0; res_rd = '0; res_we = 1'b0;
    endtask

    // Present a candidate in the current cycle
    task automatic offer(input logic [31:0] i, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [IDW-1:0] d);
        instr_valid = 1'b1; instr = i; rs1 = a; rs2 = b; id = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; instr = 32'hFFFF_FFFF; rs1 = '1; rs2 = '1; id = '1;
        tick(); rst = 1'b1; instr_valid = 1'b1;
        tick(); rst = 1'b1;
        tick(); rst = 1'b0; #1;
        total++; if (instr_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_instr_ready: got %0b want 1", instr_ready); end
        total++; if (iss_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_issue_valid: got %0b want 0", iss_valid); end
        total++; if (cmt_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_commit_valid: got %0b want 0", cmt_valid); end
        total++; if (res_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_result_ready: got %0b want 0", res_ready); end
        total++; if (iss_instr !== 32'h0) begin bad++; $display("[TB] FAIL reset_payload: got %0h want 0", iss_instr); end
        total++; if (iss_rs1 !== 64'h0) begin bad++; $display("[TB] FAIL reset_rs1: got %0h want 0", iss_rs1); end
        total++; if ({wb_valid, illegal, done, res_err, timeout} !== 5'b0) begin bad++; $display("[TB] FAIL reset_pulses: got %0b want 0", {wb_valid, illegal, done, res_err, timeout}); end
        total++; if ({wb_data, wb_rd} !== '0) begin bad++; $display("[TB] FAIL reset_wb_bus: got %0h/%0h want 0/0", wb_data, wb_rd); end
    endtask

    task automatic test_writeback();
        tick(); offer(32'h0000_005B, 64'd5, 64'd9, 3'd1); #1;
        total++; if (instr_ready !== 1'b1) begin bad++; $display("[TB] FAIL wb_c0_ready: got %0b want 1", instr_ready); end
        tick(); iss_ready = 1'b1; iss_accept = 1'b1; iss_wb = 1'b1; #1;
        total++; if (iss_valid !== 1'b1) begin bad++; $display("[TB] FAIL wb_c1_issue_valid: got %0b want 1", iss_valid); end
        total++; if (iss_instr !== 32'h0000_005B) begin bad++; $display("[TB] FAIL wb_c1_instr: got %0h want 5b", iss_instr); end
        total++; if (iss_rs1 !== 64'd5 || iss_rs2 !== 64'd9) begin bad++; $display("[TB] FAIL wb_c1_ops: got %0h/%0h want 5/9", iss_rs1, iss_rs2); end
        total++; if (iss_id !== 3'd1) begin bad++; $display("[TB] FAIL wb_c1_id: got %0d want 1", iss_id); end
        total++; if (instr_ready !== 1'b0) begin bad++; $display("[TB] FAIL wb_c1_ready: got %0b want 0", instr_ready); end
        tick(); #1;
        total++; if (cmt_valid !== 1'b1 || cmt_kill !== 1'b0) begin bad++; $display("[TB] FAIL wb_c2_commit: got v=%0b k=%0b want v=1 k=0", cmt_valid, cmt_kill); end
        total++; if (cmt_id !== 3'd1) begin bad++; $display("[TB] FAIL wb_c2_commit_id: got %0d want 1", cmt_id); end
        tick(); res_valid = 1'b1; res_id = 3'd1; res_data = 64'hA5; res_rd = 5'd3; res_we = 1'b1; #1;
        total++; if (res_ready !== 1'b1) begin bad++; $display("[TB] FAIL wb_c3_result_ready: got %0b want 1", res_ready); end
        total++; if (cmt_valid !== 1'b0) begin bad++; $display("[TB] FAIL wb_c3_commit_low: got %0b want 0", cmt_valid); end
        tick(); #1;
        total++; if (wb_valid !== 1'b1) begin bad++; $display("[TB] FAIL wb_c4_valid: got %0b want 1", wb_valid); end
        total++; if (wb_data !== 64'hA5 || wb_rd !== 5'd3) begin bad++; $display("[TB] FAIL wb_c4_data: got %0h/%0d want a5/3", wb_data, wb_rd); end
        total++; if (instr_ready !== 1'b1) begin bad++; $display("[TB] FAIL wb_c4_idle: got %0b want 1", instr_ready); end
        tick(); #1;
        total++; if (wb_valid !== 1'b0) begin bad++; $display("[TB] FAIL wb_c5_pulse_width: got %0b want 0", wb_valid); end
    endtask

    task automatic test_no_writeback();
        tick(); offer(32'h0000_002B, 64'd1, 64'd2, 3'd2);
        tick(); iss_ready = 1'b1; iss_accept = 1'b1; iss_wb = 1'b0; #1;
        total++; if (res_ready !== 1'b0) begin bad++; $display("[TB] FAIL nowb_c1_result_ready: got %0b want 0", res_ready); end
        tick(); #1;
        total++; if (cmt_valid !== 1'b1 || cmt_kill !== 1'b0 || cmt_id !== 3'd2) begin bad++; $display("[TB] FAIL nowb_c2_commit: got v=%0b k=%0b id=%0d want 1/0/2", cmt_valid, cmt_kill, cmt_id); end
        total++; if (res_ready !== 1'b0) begin bad++; $display("[TB] FAIL nowb_c2_result_ready: got %0b want 0", res_ready); end
        tick(); #1;
        total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL nowb_c3_done: got %0b want 1", done); end
        total++; if (res_ready !== 1'b0 || instr_ready !== 1'b1) begin bad++; $display("[TB] FAIL nowb_c3_state: got rr=%0b ir=%0b want 0/1", res_ready, instr_ready); end
        tick(); #1;
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL nowb_c4_done_width: got %0b want 0", done); end
    endtask

    task automatic test_reject();
        tick(); offer(32'h0000_0033, 64'd3, 64'd4, 3'd3);
        tick(); iss_ready = 1'b1; iss_accept = 1'b0; iss_wb = 1'b1;
        tick(); #1;
        total++; if (illegal !== 1'b1) begin bad++; $display("[TB] FAIL rej_c2_illegal: got %0b want 1", illegal); end
        total++; if (cmt_valid !== 1'b0) begin bad++; $display("[TB] FAIL rej_c2_no_commit: got %0b want 0", cmt_valid); end
        total++; if (instr_ready !== 1'b1) begin bad++; $display("[TB] FAIL rej_c2_ready: got %0b want 1", instr_ready); end
        tick(); #1;
        total++; if (illegal !== 1'b0 || done !== 1'b0) begin bad++; $display("[TB] FAIL rej_c3_pulses: got il=%0b dn=%0b want 0/0", illegal, done); end
    endtask

    task automatic test_flush_backpressure();
        tick(); offer(32'h0000_0077, 64'h1234, 64'h5678, 3'd4);
        for (int c = 1; c <= 4; c++) begin
            tick(); if (c == 2) flush = 1'b1; #1;
            total++; if (iss_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_c%0d_valid: got %0b want 1", c, iss_valid); end
            total++; if (iss_instr !== 32'h77 || iss_rs1 !== 64'h1234 || iss_rs2 !== 64'h5678 || iss_id !== 3'd4) begin bad++; $display("[TB] FAIL bp_c%0d_payload: got %0h/%0h/%0h/%0d want 77/1234/5678/4", c, iss_instr, iss_rs1, iss_rs2, iss_id); end
        end
        tick(); iss_ready = 1'b1; iss_accept = 1'b1; iss_wb = 1'b1;
        tick(); #1;
        total++; if (cmt_valid !== 1'b1 || cmt_kill !== 1'b1) begin bad++; $display("[TB] FAIL bp_commit_kill: got v=%0b k=%0b want 1/1", cmt_valid, cmt_kill); end
        tick(); #1;
        total++; if (done !== 1'b0 || illegal !== 1'b0) begin bad++; $display("[TB] FAIL bp_no_status: got dn=%0b il=%0b want 0/0", done, illegal); end
        total++; if (instr_ready !== 1'b1 || res_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_back_idle: got ir=%0b rr=%0b want 1/0", instr_ready, res_ready); end
    endtask

    task automatic test_wrong_id();
        tick(); offer(32'h0000_005B, 64'd7, 64'd8, 3'd1);
        tick(); iss_ready = 1'b1; iss_accept = 1'b1; iss_wb = 1'b1;
        tick();
        tick(); res_valid = 1'b1; res_id = 3'd2; res_data = 64'hDEAD; res_rd = 5'd7; res_we = 1'b1;
        tick(); #1;
        total++; if (res_err !== 1'b1) begin bad++; $display("[TB] FAIL wid_err_pulse: got %0b want 1", res_err); end
        total++; if (wb_valid !== 1'b0) begin bad++; $display("[TB] FAIL wid_no_wb: got %0b want 0", wb_valid); end
        total++; if (res_ready !== 1'b1) begin bad++; $display("[TB] FAIL wid_still_wait: got %0b want 1", res_ready); end
        tick(); res_valid = 1'b1; res_id = 3'd1; res_data = 64'h5A5A; res_rd = 5'd9; res_we = 1'b1; #1;
        total++; if (res_err !== 1'b0) begin bad++; $display("[TB] FAIL wid_err_width: got %0b want 0", res_err); end
        tick(); #1;
        total++; if (wb_valid !== 1'b1 || wb_data !== 64'h5A5A || wb_rd !== 5'd9) begin bad++; $display("[TB] FAIL wid_late_wb: got v=%0b %0h/%0d want 1 5a5a/9", wb_valid, wb_data, wb_rd); end
    endtask

    task automatic test_flush_wait();
        tick(); offer(32'h0000_005B, 64'd1, 64'd1, 3'd5);
        tick(); iss_ready = 1'b1; iss_accept = 1'b1; iss_wb = 1'b1;
        tick();
        tick(); flush = 1'b1;
        tick(); res_valid = 1'b1; res_id = 3'd5; res_data = 64'h77; res_rd = 5'd4; res_we = 1'b1;
        tick(); #1;
        total++; if (wb_valid !== 1'b0) begin bad++; $display("[TB] FAIL fw_wb_suppressed: got %0b want 0", wb_valid); end
        total++; if (instr_ready !== 1'b1) begin bad++; $display("[TB] FAIL fw_consumed: got %0b want 1", instr_ready); end
        total++; if (wb_data !== 64'h5A5A) begin bad++; $display("[TB] FAIL fw_wb_data_held: got %0h want 5a5a", wb_data); end
    endtask

    task automatic test_timeout();
        tick(); offer(32'h0000_005B, 64'd2, 64'd2, 3'd6);
        tick(); iss_ready = 1'b1; iss_accept = 1'b1; iss_wb = 1'b1;
        tick();
`ifdef CVXIF_TIMEOUT_EN
        for (int c = 0; c < 8; c++) begin
            tick(); #1;
            total++; if (timeout !== 1'b0 || res_ready !== 1'b1) begin bad++; $display("[TB] FAIL tmo_wait_%0d: got t=%0b rr=%0b want 0/1", c, timeout, res_ready); end
        end
        tick(); #1;
        total++; if (timeout !== 1'b1 || instr_ready !== 1'b1) begin bad++; $display("[TB] FAIL tmo_expire: got t=%0b ir=%0b want 1/1", timeout, instr_ready); end
        tick(); #1;
        total++; if (timeout !== 1'b0) begin bad++; $display("[TB] FAIL tmo_width: got %0b want 0", timeout); end
`else
        for (int c = 0; c < 12; c++) begin
            tick(); #1;
            total++; if (timeout !== 1'b0 || res_ready !== 1'b1) begin bad++; $display("[TB] FAIL notmo_wait_%0d: got t=%0b rr=%0b want 0/1", c, timeout, res_ready); end
        end
        tick(); res_valid = 1'b1; res_id = 3'd6; res_data = 64'h99; res_rd = 5'd2; res_we = 1'b1;
        tick(); #1;
        total++; if (wb_valid !== 1'b1 || wb_data !== 64'h99) begin bad++; $display("[TB] FAIL notmo_wb: got v=%0b %0h want 1/99", wb_valid, wb_data); end
`endif
    endtask

    task automatic test_reset_mid();
        tick(); offer(32'h0000_005B, 64'd3, 64'd3, 3'd7);
        tick(); rst = 1'b1;
        tick(); rst = 1'b0; #1;
        total++; if (cmt_valid !== 1'b0 || cmt_kill !== 1'b0) begin bad++; $display("[TB] FAIL rmid_no_commit: got v=%0b k=%0b want 0/0", cmt_valid, cmt_kill); end
        total++; if (iss_valid !== 1'b0 || instr_ready !== 1'b1) begin bad++; $display("[TB] FAIL rmid_idle: got iv=%0b ir=%0b want 0/1", iss_valid, instr_ready); end
        total++; if (iss_instr !== 32'h0) begin bad++; $display("[TB] FAIL rmid_payload_cleared: got %0h want 0", iss_instr); end
    endtask

    initial begin
        instr_valid = 1'b0; flush = 1'b0;
        iss_ready = 1'b0; iss_accept = 1'b0; iss_wb = 1'b0; iss_exc = 1'b0;
        res_valid = 1'b0; res_id = '0; res_data = '0; res_rd = '0; res_we = 1'b0;
        test_reset();
        test_writeback();
        test_no_writeback();
        test_reject();
        test_flush_backpressure();
        test_wrong_id();
        test_flush_wait();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
